moore_sequence_detector: RTL and testbench

Moore-style main control FSM for the multicycle MIPS processor. Sequences each instruction through fetch, decode, execute, memory and write-back states and drives every datapath mux select, register load enable and memory/PC write strobe. Outputs depend only on the current state and an internal ALU-operation register loaded in DECODE; there is no combinational path from Op/Funct to any output.

---
 rtl/moore_sequence_detector.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_moore_sequence_detector.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/moore_sequence_detector.sv
// Main control FSM for the multicycle MIPS datapath.
// Moore machine: every output decodes from the state register and the
// ALU-op register only. Op/Funct are looked at only when leaving DECODE
// or MEMADR.
//
// state    | meaning
// ---------+--------------------------------------------------
// FETCH    | IR <- mem[PC], PC <- PC + 4
// DECODE   | A/B <- regfile, ALUOut <- branch target, latch ALU op
// MEMADR   | ALUOut <- A + sign-extended immediate (lw/sw)
// MEMREAD  | MDR <- RAM[ALUOut]
// MEMWB    | rt <- MDR
// MEMWRITE | RAM[ALUOut] <- B
// REXEC    | ALUOut <- A op B
// ALUWB    | rd <- ALUOut
// IEXEC    | ALUOut <- A op immediate
// IWB      | rt <- ALUOut
// BEQ      | PC <- ALUOut if A == B
// BNE      | PC <- ALUOut if A != B
// JUMP     | PC <- pseudo-direct target
// JR       | PC <- A
// JAL      | $31 <- PC, PC <- pseudo-direct target

module moore_sequence_detector #(
    parameter int WORD_LENGTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WORD_LENGTH-1:0] Op,
    input  logic [WORD_LENGTH-1:0] Funct,
    output logic                   IorD,
    output logic                   Ram_Rom,
    output logic                   MemWrite,
    output logic                   IRWrite,
    output logic                   Data,
    output logic                   ALUout,
    output logic                   RegisterA,
    output logic                   RegisterB,
    output logic                   RegDst,
    output logic                   MemtoReg,
    output logic                   RegWrite,
    output logic                   ALUSrcA,
    output logic [1:0]             ALUSrcB,
    output logic [WORD_LENGTH-2:0] ALUControl,
    output logic                   PCSrc,
    output logic                   PCWrite,
    output logic                   BeqBranch,
    output logic                   BneBranch,
    output logic                   JumpCtrl,
    output logic                   JalCtrl
);

    localparam int CTL_W = WORD_LENGTH - 1;

    // Opcodes and function codes held at 32 bits so a code wider than the
    // Op/Funct ports can never compare equal to a zero-extended input.
    localparam logic [31:0] OP_R    = 32'h00;
    localparam logic [31:0] OP_J    = 32'h02;
    localparam logic [31:0] OP_JAL  = 32'h03;
    localparam logic [31:0] OP_BEQ  = 32'h04;
    localparam logic [31:0] OP_BNE  = 32'h05;
    localparam logic [31:0] OP_ADDI = 32'h08;
    localparam logic [31:0] OP_ANDI = 32'h0C;
    localparam logic [31:0] OP_ORI  = 32'h0D;
    localparam logic [31:0] OP_LUI  = 32'h0F;
    localparam logic [31:0] OP_LW   = 32'h23;
    localparam logic [31:0] OP_SW   = 32'h2B;

    localparam logic [31:0] FN_SLL  = 32'h00;
    localparam logic [31:0] FN_SRL  = 32'h02;
    localparam logic [31:0] FN_JR   = 32'h08;
    localparam logic [31:0] FN_ADD  = 32'h20;
    localparam logic [31:0] FN_SUB  = 32'h22;
    localparam logic [31:0] FN_AND  = 32'h24;
    localparam logic [31:0] FN_OR   = 32'h25;
    localparam logic [31:0] FN_SLT  = 32'h2A;

    // ALU operation codes occupy the low three bits of ALUControl.
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_LUI = 3'b011;
    localparam logic [2:0] ALU_SLL = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, REXEC, ALUWB,
        IEXEC, IWB, BEQ, BNE, JUMP, JR, JAL
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] alu_op_q, alu_op_d;

    logic [31:0] op_w, funct_w;
    logic is_r, is_j, is_jal, is_beq, is_bne, is_addi, is_andi, is_ori;
    logic is_lui, is_lw, is_sw, is_itype;
    logic fn_jr, fn_alu;
    logic [2:0] alu_dec;
    logic [2:0] alu_sel;

    assign op_w    = 32'(Op);
    assign funct_w = 32'(Funct);

    // Instruction class decode from the (IR-held) opcode and function field.
    always_comb begin
        is_r     = (op_w == OP_R);
        is_j     = (op_w == OP_J);
        is_jal   = (op_w == OP_JAL);
        is_beq   = (op_w == OP_BEQ);
        is_bne   = (op_w == OP_BNE);
        is_addi  = (op_w == OP_ADDI);
        is_andi  = (op_w == OP_ANDI);
        is_ori   = (op_w == OP_ORI);
        is_lui   = (op_w == OP_LUI);
        is_lw    = (op_w == OP_LW);
        is_sw    = (op_w == OP_SW);
        is_itype = is_addi | is_andi | is_ori | is_lui;
        fn_jr    = (funct_w == FN_JR);
        fn_alu   = (funct_w == FN_SLL) | (funct_w == FN_SRL) | (funct_w == FN_ADD) |
                   (funct_w == FN_SUB) | (funct_w == FN_AND) | (funct_w == FN_OR)  |
                   (funct_w == FN_SLT);
    end

    // ALU operation implied by the instruction; unknown encodings fall back to ADD.
    always_comb begin
        alu_dec = ALU_ADD;
        if (is_andi)                            alu_dec = ALU_AND;
        else if (is_ori)                        alu_dec = ALU_OR;
        else if (is_lui)                        alu_dec = ALU_LUI;
        else if (is_r) begin
            if (funct_w == FN_SLL)              alu_dec = ALU_SLL;
            else if (funct_w == FN_SRL)         alu_dec = ALU_SRL;
            else if (funct_w == FN_SUB)         alu_dec = ALU_SUB;
            else if (funct_w == FN_AND)         alu_dec = ALU_AND;
            else if (funct_w == FN_OR)          alu_dec = ALU_OR;
            else if (funct_w == FN_SLT)         alu_dec = ALU_SLT;
        end
    end

    // State and ALU-op registers; reset drops straight back to FETCH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= FETCH;
            alu_op_q <= ALU_ADD;
        end else begin
            state_q  <= state_d;
            alu_op_q <= alu_op_d;
        end
    end

    // Next-state logic; the ALU-op register only reloads in DECODE.
    always_comb begin
        state_d  = state_q;
        alu_op_d = alu_op_q;
        case (state_q)
            FETCH:    state_d = DECODE;
            DECODE: begin
                alu_op_d = alu_dec;
                if (is_lw || is_sw)         state_d = MEMADR;
                else if (is_r && fn_jr)     state_d = JR;
                else if (is_r && fn_alu)    state_d = REXEC;
                else if (is_itype)          state_d = IEXEC;
                else if (is_beq)            state_d = BEQ;
                else if (is_bne)            state_d = BNE;
                else if (is_j)              state_d = JUMP;
                else if (is_jal)            state_d = JAL;
                else                        state_d = FETCH;
            end
            MEMADR: begin
                if (is_lw)                  state_d = MEMREAD;
                else if (is_sw)             state_d = MEMWRITE;
                else                        state_d = FETCH;
            end
            MEMREAD:  state_d = MEMWB;
            REXEC:    state_d = ALUWB;
            IEXEC:    state_d = IWB;
            default:  state_d = FETCH;
        endcase
    end

    // Output decode from the registered state and ALU-op only.
    always_comb begin
        IorD      = 1'b0;
        Ram_Rom   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        Data      = 1'b0;
        ALUout    = 1'b0;
        RegisterA = 1'b0;
        RegisterB = 1'b0;
        RegDst    = 1'b0;
        MemtoReg  = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        alu_sel   = ALU_AND;
        PCSrc     = 1'b0;
        PCWrite   = 1'b0;
        BeqBranch = 1'b0;
        BneBranch = 1'b0;
        JumpCtrl  = 1'b0;
        JalCtrl   = 1'b0;
        case (state_q)
            FETCH: begin
                IRWrite = 1'b1;
                ALUSrcB = 2'b01;
                alu_sel = ALU_ADD;
                PCWrite = 1'b1;
            end
            DECODE: begin
                RegisterA = 1'b1;
                RegisterB = 1'b1;
                ALUout    = 1'b1;
                ALUSrcB   = 2'b11;
                alu_sel   = ALU_ADD;
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                alu_sel = ALU_ADD;
                ALUout  = 1'b1;
            end
            MEMREAD: begin
                IorD    = 1'b1;
                Ram_Rom = 1'b1;
                Data    = 1'b1;
            end
            MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            MEMWRITE: begin
                IorD     = 1'b1;
                Ram_Rom  = 1'b1;
                MemWrite = 1'b1;
            end
            REXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b00;
                alu_sel = alu_op_q;
                ALUout  = 1'b1;
            end
            ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                alu_sel = alu_op_q;
                ALUout  = 1'b1;
            end
            IWB: begin
                RegWrite = 1'b1;
            end
            BEQ: begin
                ALUSrcA   = 1'b1;
                alu_sel   = ALU_SUB;
                PCSrc     = 1'b1;
                BeqBranch = 1'b1;
            end
            BNE: begin
                ALUSrcA   = 1'b1;
                alu_sel   = ALU_SUB;
                PCSrc     = 1'b1;
                BneBranch = 1'b1;
            end
            JUMP: begin
                JumpCtrl = 1'b1;
                PCWrite  = 1'b1;
            end
            JR: begin
                JumpCtrl = 1'b1;
                PCWrite  = 1'b1;
                PCSrc    = 1'b1;
            end
            JAL: begin
                JumpCtrl = 1'b1;
                PCWrite  = 1'b1;
                JalCtrl  = 1'b1;
                RegWrite = 1'b1;
            end
            default: ;
        endcase
        ALUControl = CTL_W'(alu_sel);
    end

endmodule

// File: tb/tb_moore_sequence_detector.sv
// Bench for moore_sequence_detector: a default-width (5) and a 6-bit
// instance share clock and reset. Expected per-cycle control words come
// from an instruction-level model of what each MIPS instruction needs.

module tb_moore_sequence_detector;

    typedef struct packed {
        logic       iord;
        logic       ram_rom;
        logic       mem_write;
        logic       ir_write;
        logic       data;
        logic       alu_out;
        logic       reg_a;
        logic       reg_b;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [7:0] alu_ctl;
        logic       pc_src;
        logic       pc_write;
        logic       beq;
        logic       bne;
        logic       jump;
        logic       jal;
    } ctl_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [4:0] op5 = '0, funct5 = '0;
    logic [5:0] op6 = '0, funct6 = '0;

    logic iord5, ramrom5, memwr5, irwr5, data5, aluout5, rega5, regb5;
    logic regdst5, memtoreg5, regwr5, srca5, pcsrc5, pcwr5, beq5, bne5, jmp5, jal5;
    logic [1:0] srcb5;
    logic [3:0] aluctl5;

    logic iord6, ramrom6, memwr6, irwr6, data6, aluout6, rega6, regb6;
    logic regdst6, memtoreg6, regwr6, srca6, pcsrc6, pcwr6, beq6, bne6, jmp6, jal6;
    logic [1:0] srcb6;
    logic [4:0] aluctl6;

    ctl_t obs5, obs6;
    ctl_t exp_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    moore_sequence_detector #(.WORD_LENGTH(5)) dut5 (
        .clk(clk), .reset(reset), .Op(op5), .Funct(funct5),
        .IorD(iord5), .Ram_Rom(ramrom5), .MemWrite(memwr5), .IRWrite(irwr5),
        .Data(data5), .ALUout(aluout5), .RegisterA(rega5), .RegisterB(regb5),
        .RegDst(regdst5), .MemtoReg(memtoreg5), .RegWrite(regwr5),
        .ALUSrcA(srca5), .ALUSrcB(srcb5), .ALUControl(aluctl5), .PCSrc(pcsrc5),
        .PCWrite(pcwr5), .BeqBranch(beq5), .BneBranch(bne5),
        .JumpCtrl(jmp5), .JalCtrl(jal5)
    );

    moore_sequence_detector #(.WORD_LENGTH(6)) dut6 (
        .clk(clk), .reset(reset), .Op(op6), .Funct(funct6),
        .IorD(iord6), .Ram_Rom(ramrom6), .MemWrite(memwr6), .IRWrite(irwr6),
        .Data(data6), .ALUout(aluout6), .RegisterA(rega6), .RegisterB(regb6),
        .RegDst(regdst6), .MemtoReg(memtoreg6), .RegWrite(regwr6),
        .ALUSrcA(srca6), .ALUSrcB(srcb6), .ALUControl(aluctl6), .PCSrc(pcsrc6),
        .PCWrite(pcwr6), .BeqBranch(beq6), .BneBranch(bne6),
        .JumpCtrl(jmp6), .JalCtrl(jal6)
    );

    // Gather each instance's outputs into one comparable word.
    always_comb begin
        obs5 = '0;
        obs5.iord = iord5;        obs5.ram_rom = ramrom5;   obs5.mem_write = memwr5;
        obs5.ir_write = irwr5;    obs5.data = data5;        obs5.alu_out = aluout5;
        obs5.reg_a = rega5;       obs5.reg_b = regb5;       obs5.reg_dst = regdst5;
        obs5.mem_to_reg = memtoreg5; obs5.reg_write = regwr5; obs5.alu_src_a = srca5;
        obs5.alu_src_b = srcb5;   obs5.alu_ctl = 8'(aluctl5); obs5.pc_src = pcsrc5;
        obs5.pc_write = pcwr5;    obs5.beq = beq5;          obs5.bne = bne5;
        obs5.jump = jmp5;         obs5.jal = jal5;
    end

    always_comb begin
        obs6 = '0;
        obs6.iord = iord6;        obs6.ram_rom = ramrom6;   obs6.mem_write = memwr6;
        obs6.ir_write = irwr6;    obs6.data = data6;        obs6.alu_out = aluout6;
        obs6.reg_a = rega6;       obs6.reg_b = regb6;       obs6.reg_dst = regdst6;
        obs6.mem_to_reg = memtoreg6; obs6.reg_write = regwr6; obs6.alu_src_a = srca6;
        obs6.alu_src_b = srcb6;   obs6.alu_ctl = 8'(aluctl6); obs6.pc_src = pcsrc6;
        obs6.pc_write = pcwr6;    obs6.beq = beq6;          obs6.bne = bne6;
        obs6.jump = jmp6;         obs6.jal = jal6;
    end

    // A code is reachable only if it fits in the port width.
    function automatic bit hit(input int w, input int v, input int code);
        return (code < (1 << w)) && (v == code);
    endfunction

    function automatic int funct_alu(input int w, input int f);
        if (hit(w, f, 'h00)) return 4;
        if (hit(w, f, 'h02)) return 5;
        if (hit(w, f, 'h20)) return 2;
        if (hit(w, f, 'h22)) return 6;
        if (hit(w, f, 'h24)) return 0;
        if (hit(w, f, 'h25)) return 1;
        if (hit(w, f, 'h2A)) return 7;
        return -1;
    endfunction

    function automatic ctl_t fetch_word();
        ctl_t c = '0;
        c.ir_write = 1'b1; c.alu_src_b = 2'b01; c.alu_ctl = 8'd2; c.pc_write = 1'b1;
        return c;
    endfunction

    function automatic ctl_t exec_word(input logic [1:0] srcb, input int alu);
        ctl_t c = '0;
        c.alu_src_a = 1'b1; c.alu_src_b = srcb; c.alu_ctl = 8'(alu); c.alu_out = 1'b1;
        return c;
    endfunction

    // Instruction-level model: the list of control words the datapath needs,
    // one per cycle, for a single instruction starting at its fetch.
    task automatic build_expected(input int w, input int op, input int funct);
        ctl_t c;
        int   a;
        exp_q.delete();
        exp_q.push_back(fetch_word());
        c = '0;
        c.reg_a = 1'b1; c.reg_b = 1'b1; c.alu_out = 1'b1; c.alu_src_b = 2'b11; c.alu_ctl = 8'd2;
        exp_q.push_back(c);
        if (hit(w, op, 'h23)) begin
            exp_q.push_back(exec_word(2'b10, 2));
            c = '0; c.iord = 1'b1; c.ram_rom = 1'b1; c.data = 1'b1;
            exp_q.push_back(c);
            c = '0; c.mem_to_reg = 1'b1; c.reg_write = 1'b1;
            exp_q.push_back(c);
        end else if (hit(w, op, 'h2B)) begin
            exp_q.push_back(exec_word(2'b10, 2));
            c = '0; c.iord = 1'b1; c.ram_rom = 1'b1; c.mem_write = 1'b1;
            exp_q.push_back(c);
        end else if (op == 0) begin
            a = funct_alu(w, funct);
            if (hit(w, funct, 'h08)) begin
                c = '0; c.jump = 1'b1; c.pc_write = 1'b1; c.pc_src = 1'b1;
                exp_q.push_back(c);
            end else if (a >= 0) begin
                exp_q.push_back(exec_word(2'b00, a));
                c = '0; c.reg_dst = 1'b1; c.reg_write = 1'b1;
                exp_q.push_back(c);
            end
        end else if (op == 'h08 || op == 'h0C || op == 'h0D || op == 'h0F) begin
            a = (op == 'h08) ? 2 : (op == 'h0C) ? 0 : (op == 'h0D) ? 1 : 3;
            exp_q.push_back(exec_word(2'b10, a));
            c = '0; c.reg_write = 1'b1;
            exp_q.push_back(c);
        end else if (op == 'h04 || op == 'h05) begin
            c = '0; c.alu_src_a = 1'b1; c.alu_ctl = 8'd6; c.pc_src = 1'b1;
            c.beq = (op == 'h04); c.bne = (op == 'h05);
            exp_q.push_back(c);
        end else if (op == 'h02 || op == 'h03) begin
            c = '0; c.jump = 1'b1; c.pc_write = 1'b1;
            c.jal = (op == 'h03); c.reg_write = (op == 'h03);
            exp_q.push_back(c);
        end
    endtask

    task automatic check(input string tag, input int k, input ctl_t obs, input ctl_t exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s step %0d observed %h expected %h", tag, k, obs, exp);
        end
    endtask

    // Runs one instruction from its FETCH cycle; abort_at >= 0 pulls reset
    // low in that cycle (between edges) and expects an immediate FETCH.
    task automatic run(input int w, input int op_in, input int funct_in,
                       input string tag, input int abort_at = -1);
        int op, funct, n;
        op    = op_in & ((1 << w) - 1);
        funct = funct_in & ((1 << w) - 1);
        if (w == 5) begin op5 = 5'(op); funct5 = 5'(funct); end
        else        begin op6 = 6'(op); funct6 = 6'(funct); end
        build_expected(w, op, funct);
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            check(tag, k, (w == 5) ? obs5 : obs6, exp_q[k]);
            if (k == abort_at) begin
                #1 reset = 1'b0;
                #1 check({tag, "_abort"}, k, (w == 5) ? obs5 : obs6, fetch_word());
                #1 reset = 1'b1;
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic random_instr(input int w, input string tag);
        int ops[12] = '{'h00, 'h00, 'h02, 'h03, 'h04, 'h05, 'h08, 'h0C, 'h0D, 'h0F, 'h23, 'h2B};
        int fns[8]  = '{'h00, 'h02, 'h08, 'h20, 'h22, 'h24, 'h25, 'h2A};
        int op, funct;
        op    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, (1 << w) - 1))
                                            : ops[$urandom_range(0, 11)];
        funct = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, (1 << w) - 1))
                                            : fns[$urandom_range(0, 7)];
        if (op >= (1 << w))    op    = int'($urandom_range(0, (1 << w) - 1));
        if (funct >= (1 << w)) funct = int'($urandom_range(0, (1 << w) - 1));
        run(w, op, funct, tag);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check("reset5", 0, obs5, fetch_word());
        check("reset6", 0, obs6, fetch_word());
        #1 reset = 1'b1;
        #1;

        run(5, 'h08, 0, "addi");
        run(5, 'h08, 0, "addi2");
        run(5, 'h05, 0, "bne");
        run(5, 'h04, 0, "beq");
        run(5, 'h00, 'h00, "sll");
        run(5, 'h00, 'h02, "srl");
        run(5, 'h00, 'h08, "jr");
        run(5, 'h03, 0, "jal");
        run(5, 'h02, 0, "j");
        run(5, 'h0C, 0, "andi");
        run(5, 'h0D, 0, "ori");
        run(5, 'h0F, 0, "lui");
        run(5, 'h1F, 0, "nop_op");
        run(5, 'h00, 'h1F, "nop_funct");
        run(5, 'h00, 'h00, "sll_reset", 2);
        run(5, 'h08, 0, "addi_after_reset");
        for (int i = 0; i < 30; i++) random_instr(5, "rand5");

        reset = 1'b0;
        #1 check("reset6_mid", 0, obs6, fetch_word());
        reset = 1'b1;
        #1;
        run(6, 'h23, 0, "lw");
        run(6, 'h2B, 0, "sw");
        run(6, 'h00, 'h20, "add");
        run(6, 'h00, 'h22, "sub");
        run(6, 'h00, 'h24, "and");
        run(6, 'h00, 'h25, "or");
        run(6, 'h00, 'h2A, "slt");
        run(6, 'h3F, 0, "nop6");
        for (int i = 0; i < 30; i++) random_instr(6, "rand6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
